// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first, with one borrow flop.
// Optional signed-overflow output ovf when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic             borrow_reg;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;

    logic bit_d, borrow_next, last_bit, accept;

    assign bit_d       = a_sh_reg[0] ^ b_sh_reg[0] ^ borrow_reg;
    assign borrow_next = (~a_sh_reg[0] & b_sh_reg[0]) | (~a_sh_reg[0] & borrow_reg)
                       | (b_sh_reg[0] & borrow_reg);
    assign last_bit    = (cnt_reg == CW'(WIDTH - 1));
    assign accept      = (state_reg == IDLE) && start_valid;

    always_comb begin
        state_next  = state_reg;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_next = RUN;
            end
            RUN: begin
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
        end else if (accept) begin
            cnt_reg    <= '0;
            borrow_reg <= bin;
            a_sh_reg   <= a;
            b_sh_reg   <= b;
        end else if (state_reg == RUN) begin
            // Result fills from the MSB side so bit 0 lands in place after WIDTH shifts.
            diff_reg   <= {bit_d, diff_reg[WIDTH-1:1]};
            a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
            b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
            borrow_reg <= borrow_next;
            cnt_reg    <= cnt_reg + 1'b1;
            if (last_bit) bout_reg <= borrow_next;
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out during RUN, so keep copies for the final decision.
    logic a_msb_reg, b_msb_reg, ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
        end else if ((state_reg == RUN) && last_bit) begin
            ovf_reg <= (a_msb_reg != b_msb_reg) && (bit_d != a_msb_reg);
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor: table-driven operations plus
// hand-written backpressure, mid-run reset and back-to-back sequences.
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a, b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             done_valid;
    logic             done_ready;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .diff       (diff),
        .bout       (bout),
`ifdef SERIAL_SUB_OVF_EN
        .ovf        (ovf),
`endif
        .done_valid (done_valid),
        .done_ready (done_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic             vbin;
        logic [WIDTH-1:0] exp_diff;
        logic             exp_bout;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Called at the negedge right after the handshake edge; counts edges until done_valid.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done_valid && cycles < 4 * WIDTH) begin
            @(negedge clk);
            cycles++;
        end
        check("latency", cycles, WIDTH);
    endtask

    task automatic do_op(input vec_t v);
        int cyc;
        int guard;
        a = v.va; b = v.vb; bin = v.vbin; start_valid = 1'b1;
        guard = 0;
        while (!start_ready && guard < 4 * WIDTH) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        a = ~v.va; b = ~v.vb; bin = ~v.vbin;
        check("start_ready_low", start_ready, 1'b0);
        wait_done(cyc);
        check("diff", diff, v.exp_diff);
        check("bout", bout, v.exp_bout);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", ovf, v.exp_ovf);
`endif
        $display("op a=%0h b=%0h bin=%0b -> diff=%0h bout=%0b latency=%0d",
                 v.va, v.vb, v.vbin, diff, bout, cyc);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check("done_valid_clear", done_valid, 1'b0);
        check("start_ready_back", start_ready, 1'b1);
    endtask

    initial begin
        int cyc;
        logic [WIDTH-1:0] held_diff;
        logic             held_bout;

        //          a      b      bin   diff   bout  ovf
        vecs[0]  = '{4'd9,  4'd5,  1'b0, 4'h4, 1'b0, 1'b1};
        vecs[1]  = '{4'd3,  4'd5,  1'b0, 4'hE, 1'b1, 1'b0};
        vecs[2]  = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1, 1'b0};
        vecs[3]  = '{4'd15, 4'd15, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[4]  = '{4'd12, 4'd3,  1'b0, 4'h9, 1'b0, 1'b0};
        vecs[5]  = '{4'd0,  4'd15, 1'b0, 4'h1, 1'b1, 1'b0};
        vecs[6]  = '{4'd15, 4'd0,  1'b1, 4'hE, 1'b0, 1'b0};
        vecs[7]  = '{4'd8,  4'd8,  1'b0, 4'h0, 1'b0, 1'b0};
        vecs[8]  = '{4'd7,  4'd2,  1'b1, 4'h4, 1'b0, 1'b0};
        vecs[9]  = '{4'd2,  4'd3,  1'b1, 4'hE, 1'b1, 1'b0};
        vecs[10] = '{4'd5,  4'd5,  1'b1, 4'hF, 1'b1, 1'b0};
        vecs[11] = '{4'd7,  4'd8,  1'b0, 4'hF, 1'b1, 1'b1};
        vecs[12] = '{4'd8,  4'd1,  1'b0, 4'h7, 1'b0, 1'b1};
        vecs[13] = '{4'd5,  4'd2,  1'b0, 4'h3, 1'b0, 1'b0};

        rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_diff", diff, 4'h0);
        check("rst_bout", bout, 1'b0);
        check("rst_done_valid", done_valid, 1'b0);
        check("rst_start_ready", start_ready, 1'b1);
        $display("reset: diff=%0h bout=%0b done_valid=%0b start_ready=%0b",
                 diff, bout, done_valid, start_ready);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) do_op(vecs[i]);

        // Backpressure: result holds, new requests ignored while DONE.
        a = 4'd6; b = 4'd1; bin = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        wait_done(cyc);
        check("bp_diff", diff, 4'h5);
        held_diff = diff;
        held_bout = bout;
        for (int i = 0; i < 3; i++) begin
            a = 4'd0; b = 4'd1; start_valid = (i != 1);
            @(negedge clk);
            check("bp_done_valid", done_valid, 1'b1);
            check("bp_start_ready", start_ready, 1'b0);
            check("bp_diff_hold", diff, held_diff);
            check("bp_bout_hold", bout, held_bout);
            $display("backpressure cycle %0d: diff=%0h bout=%0b done_valid=%0b", i, diff, bout, done_valid);
        end
        start_valid = 1'b0;
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check("bp_release_idle", start_ready, 1'b1);
        check("bp_release_valid", done_valid, 1'b0);
        repeat (2) @(negedge clk);
        check("bp_no_ghost_start", start_ready, 1'b1);
        check("bp_no_ghost_done", done_valid, 1'b0);

        // Reset asserted after two RUN cycles aborts immediately.
        a = 4'd12; b = 4'd3; bin = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_diff", diff, 4'h0);
        check("midrst_bout", bout, 1'b0);
        check("midrst_done_valid", done_valid, 1'b0);
        check("midrst_start_ready", start_ready, 1'b1);
        $display("mid-run reset: diff=%0h bout=%0b done_valid=%0b", diff, bout, done_valid);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(vecs[4]);

        // Back-to-back: second request held high throughout the first operation.
        a = 4'd9; b = 4'd5; bin = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 4'd3; b = 4'd5; bin = 1'b0;
        wait_done(cyc);
        check("b2b_first_diff", diff, 4'h4);
        check("b2b_first_bout", bout, 1'b0);
        $display("b2b first: diff=%0h bout=%0b", diff, bout);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check("b2b_idle_ready", start_ready, 1'b1);
        check("b2b_idle_valid", done_valid, 1'b0);
        @(negedge clk);
        start_valid = 1'b0;
        check("b2b_second_accepted", start_ready, 1'b0);
        wait_done(cyc);
        check("b2b_second_diff", diff, 4'hE);
        check("b2b_second_bout", bout, 1'b1);
        $display("b2b second: diff=%0h bout=%0b", diff, bout);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
